// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: four SPI modes per transfer, programmable sck divider,
// NUM_CS active-low chip selects, start/busy/done handshake toward the local controller.
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_CS    = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_transit,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  // state   | meaning
  // S_IDLE  | cs high, sck tracks mode[1], waiting for a start
  // S_LEAD  | cs low, sck idle for one half-period
  // S_XFER  | 2*DATA_W half-periods, each ending in an sck edge
  // S_TRAIL | cs low, sck idle, mosi holds last bit for one half-period
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(2 * DATA_W);
  localparam int CSW1  = CSW + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(2 * DATA_W - 1);
  localparam logic [CSW:0]     CS_LIMIT = CSW1'(NUM_CS);

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [HP_W-1:0]   r_hp;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [1:0]        r_mode;
  logic              r_sck, r_mosi, r_busy, r_done;
  logic [NUM_CS-1:0] r_cs, w_cs_dec;

  logic w_accept, w_div_tc, w_edge, w_lead, w_trail, w_last, w_sample, w_shift, w_finish;
  logic w_data_first, w_tx_bit;
  logic [DATA_W-1:0] w_data_shift, w_tx_shift, w_rx_shift;

  assign w_div_tc     = (r_div == '0);
  assign w_data_first = MSB_FIRST ? data[DATA_W-1] : data[0];
  assign w_data_shift = MSB_FIRST ? {data[DATA_W-2:0], 1'b0} : {1'b0, data[DATA_W-1:1]};
  assign w_tx_bit     = MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0];
  assign w_tx_shift   = MSB_FIRST ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};
  assign w_rx_shift   = MSB_FIRST ? {r_rx[DATA_W-2:0], miso} : {miso, r_rx[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LEAD;
      S_LEAD:  if (w_div_tc) w_state_nxt = S_XFER;
      S_XFER:  if (w_div_tc && (r_hp == '0)) w_state_nxt = S_TRAIL;
      S_TRAIL: if (w_div_tc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_hp counts half-periods down from 2*DATA_W-1: odd values end in a leading edge.
  always_comb begin
    w_accept = (r_state == S_IDLE) && en_transit && ({1'b0, cs_sel} < CS_LIMIT);
    w_edge   = (r_state == S_XFER) && w_div_tc;
    w_lead   = w_edge && r_hp[0];
    w_trail  = w_edge && !r_hp[0];
    w_last   = w_trail && (r_hp == '0);
    w_sample = r_mode[0] ? w_trail : w_lead;
    w_shift  = r_mode[0] ? w_lead : (w_trail && !w_last);
    w_finish = (r_state == S_TRAIL) && w_div_tc;
  end

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) w_cs_dec[i] = (cs_sel != CSW'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_hp      <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_mode    <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) r_sck <= mode[1];
      if (w_accept) begin
        r_mode <= mode;
        r_div  <= DIV_LOAD;
        r_hp   <= HP_LOAD;
        r_cs   <= w_cs_dec;
        r_busy <= 1'b1;
        r_rx   <= '0;
        // CPHA=0 must present the first bit before the first leading edge.
        if (mode[0]) begin
          r_tx   <= data;
          r_mosi <= 1'b0;
        end else begin
          r_tx   <= w_data_shift;
          r_mosi <= w_data_first;
        end
      end else if (r_state != S_IDLE) begin
        r_div <= w_div_tc ? DIV_LOAD : r_div - 1'b1;
        if (w_edge) begin
          r_sck <= ~r_sck;
          r_hp  <= r_hp - 1'b1;
        end
        if (w_sample) r_rx <= w_rx_shift;
        if (w_shift) begin
          r_mosi <= w_tx_bit;
          r_tx   <= w_tx_shift;
        end
        if (w_finish) begin
          r_cs      <= '1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
          r_mosi    <= 1'b0;
          r_sck     <= r_mode[1];
        end
      end
    end
  end

  assign sck     = r_sck;
  assign mosi    = r_mosi;
  assign cs      = r_cs;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: two configurations driven through a shared
// behavioural SPI slave and transaction-level expectations.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        tb_en = 1'b0;
  logic [15:0] tb_data = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  cs_sel = '0;
  logic        sel = 1'b0;
  logic        lb = 1'b0;
  logic        en0, en1, miso;

  logic       sck0, mosi0, busy0, done0;
  logic [2:0] cs0;
  logic [7:0] rx0;
  logic       sck1, mosi1, busy1, done1;
  logic [3:0] cs1;
  logic [15:0] rx1;

  assign en0 = tb_en && (sel == 1'b0);
  assign en1 = tb_en && (sel == 1'b1);

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(3), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .en_transit(en0), .data(tb_data[7:0]), .mode(mode),
    .cs_sel(cs_sel), .miso(miso), .sck(sck0), .mosi(mosi0), .cs(cs0), .busy(busy0),
    .done(done0), .rx_data(rx0));

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(4), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .en_transit(en1), .data(tb_data), .mode(mode),
    .cs_sel(cs_sel), .miso(miso), .sck(sck1), .mosi(mosi1), .cs(cs1), .busy(busy1),
    .done(done1), .rx_data(rx1));

  logic        m_sck, m_mosi, m_busy, m_done;
  logic [3:0]  m_cs;
  logic [15:0] m_rx;

  always_comb begin
    if (sel == 1'b0) begin
      m_sck = sck0; m_mosi = mosi0; m_cs = {1'b1, cs0}; m_busy = busy0; m_done = done0;
      m_rx = {8'h00, rx0};
    end else begin
      m_sck = sck1; m_mosi = mosi1; m_cs = cs1; m_busy = busy1; m_done = done1;
      m_rx = rx1;
    end
  end

  // Transaction expectations for the currently selected DUT.
  int          t_dw = 8, t_cd = 2, t_len = 36;
  logic        t_msb = 1'b1, t_cpol = 1'b0, t_cpha = 1'b0;
  logic [3:0]  t_cs = 4'hE;
  logic [15:0] s_tx = '0, t_exp_rx = '0, t_exp_srx = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bpos(input int k);
    return t_msb ? (t_dw - 1 - k) : k;
  endfunction

  // Behavioural slave: drives miso on its shift edge, captures mosi on its sample edge.
  logic        slave_bit = 1'b0;
  logic        prev_act = 1'b0, prev_sck = 1'b0;
  logic [15:0] s_rx = '0;
  int          cs_low_cnt = 0, edges = 0, si = 0, di = 0, done_cnt = 0;

  assign miso = lb ? m_mosi : slave_bit;

  always @(negedge clk) begin
    logic act, lead;
    act = (m_cs != 4'hF);
    if (act && !prev_act) begin
      cs_low_cnt = 1; edges = 0; si = 0; di = 0; s_rx = '0; done_cnt = 0;
      if (!t_cpha) begin
        slave_bit = s_tx[bpos(0)];
        di = 1;
      end
    end else if (act) begin
      cs_low_cnt++;
      if (m_sck != prev_sck) begin
        edges++;
        lead = (m_sck != t_cpol);
        if (lead != t_cpha) begin
          if (si < t_dw) s_rx[bpos(si)] = m_mosi;
          si++;
        end else if (di < t_dw) begin
          slave_bit = s_tx[bpos(di)];
          di++;
        end
      end
    end
    if (m_done) done_cnt++;
    prev_act = act;
    prev_sck = m_sck;
  end

  task automatic setup(input logic s, input logic [15:0] d, input logic [1:0] md,
                       input logic [1:0] cssel, input logic [15:0] stx, input logic loop);
    logic [15:0] msk;
    sel = s;
    t_dw = s ? 16 : 8;
    t_cd = s ? 1 : 2;
    t_msb = s ? 1'b0 : 1'b1;
    msk = s ? 16'hFFFF : 16'h00FF;
    tb_data = d; mode = md; cs_sel = cssel; s_tx = stx; lb = loop;
    t_cpol = md[1]; t_cpha = md[0];
    t_cs = 4'hF & ~(4'h1 << cssel);
    t_len = t_cd * (2 * t_dw + 2);
    t_exp_srx = d & msk;
    t_exp_rx = (loop ? d : stx) & msk;
    repeat (2) @(posedge clk);
    #1;
    check_val("sck_idle", m_sck, t_cpol);
  endtask

  task automatic start();
    tb_en = 1'b1;
    @(posedge clk);
    #1;
    tb_en = 1'b0;
    check_val("busy_start", m_busy, 1'b1);
    check_val("cs_start", m_cs, t_cs);
  endtask

  task automatic finish(input logic poke, input logic hold, input logic scram);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 4) tb_en = 1'b1;
      if (poke && n == 5) tb_en = 1'b0;
      if (scram && n == 3) begin
        tb_data = 16'($urandom);
        mode = 2'($urandom);
        cs_sel = 2'($urandom);
      end
      if (m_done) seen = 1'b1;
    end
    check_val("done_seen", seen, 1'b1);
    check_val("latency", n, t_len);
    check_val("rx_data", m_rx, t_exp_rx);
    check_val("slave_rx", s_rx, t_exp_srx);
    check_val("sck_edges", edges, 2 * t_dw);
    check_val("cs_low_len", cs_low_cnt, t_len);
    check_val("cs_done", m_cs, 4'hF);
    check_val("busy_done", m_busy, 1'b0);
    check_val("sck_done", m_sck, t_cpol);
    if (hold) begin
      tb_en = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      check_val("done_once", done_cnt, 1);
      check_val("done_low", m_done, 1'b0);
    end
  endtask

  initial begin
    int nd;
    logic       rs;
    logic [1:0] rc;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cs0", cs0, 3'b111);
    check_val("rst_cs1", cs1, 4'hF);
    check_val("rst_sck", {sck0, sck1}, 2'b00);
    check_val("rst_mosi", {mosi0, mosi1}, 2'b00);
    check_val("rst_busy", {busy0, busy1}, 2'b00);
    check_val("rst_done", {done0, done1}, 2'b00);
    check_val("rst_rx", {rx0, rx1}, 24'h0);
    reset = 1'b0;

    // Mode 0 loopback of 0xA5.
    setup(1'b0, 16'h00A5, 2'b00, 2'd0, 16'h0000, 1'b1);
    start();
    check_val("mosi_first_a5", m_mosi, 1'b1);
    finish(1'b0, 1'b0, 1'b0);

    // Modes 3, 1, 2 against a slave returning 0x3C.
    setup(1'b0, 16'($urandom), 2'b11, 2'd1, 16'h003C, 1'b0);
    start();
    finish(1'b0, 1'b0, 1'b0);
    setup(1'b0, 16'($urandom), 2'b01, 2'd2, 16'h003C, 1'b0);
    start();
    finish(1'b0, 1'b0, 1'b0);
    setup(1'b0, 16'($urandom), 2'b10, 2'd0, 16'h003C, 1'b0);
    start();
    finish(1'b0, 1'b0, 1'b0);

    // Start request mid-transfer is dropped.
    setup(1'b0, 16'h0096, 2'b01, 2'd2, 16'h0069, 1'b0);
    start();
    finish(1'b1, 1'b0, 1'b0);

    // Start held in the done cycle launches the next transfer after one cs-high cycle.
    setup(1'b0, 16'h003C, 2'b00, 2'd0, 16'h00E1, 1'b0);
    start();
    finish(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    tb_en = 1'b0;
    check_val("b2b_cs", m_cs, t_cs);
    check_val("b2b_busy", m_busy, 1'b1);
    finish(1'b0, 1'b0, 1'b0);

    // Chip-select decode on the four-select part.
    setup(1'b1, 16'($urandom), 2'b00, 2'd2, 16'($urandom), 1'b0);
    start();
    finish(1'b0, 1'b0, 1'b0);

    // Out-of-range select on the three-select part is ignored.
    sel = 1'b0; mode = 2'b00; cs_sel = 2'd3; tb_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("bad_sel_busy", m_busy, 1'b0);
      check_val("bad_sel_cs", m_cs, 4'hF);
    end
    tb_en = 1'b0;

    // Reset during the fourth bit aborts with no done pulse.
    setup(1'b0, 16'h005A, 2'b10, 2'd1, 16'h00C3, 1'b0);
    start();
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_cs", m_cs, 4'hF);
    check_val("mid_rst_sck", m_sck, 1'b0);
    check_val("mid_rst_busy", m_busy, 1'b0);
    check_val("mid_rst_done", m_done, 1'b0);
    check_val("mid_rst_rx", m_rx, 16'h0);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (m_done) nd++;
    end
    check_val("no_done_after_rst", nd, 0);

    // Divider 1, 16 bits, LSB first, loopback of 0x8001.
    setup(1'b1, 16'h8001, 2'b00, 2'd0, 16'h0000, 1'b1);
    start();
    check_val("mosi_first_8001", m_mosi, 1'b1);
    finish(1'b0, 1'b0, 1'b0);

    // Randomised transfers with inputs disturbed while busy.
    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      rc = rs ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      setup(rs, 16'($urandom), 2'($urandom), rc, 16'($urandom), ($urandom_range(0, 3) == 0));
      start();
      finish(1'b0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
